bf_program_loader: RTL and testbench
====================================

# bf_program_loader

Upstream stage of the brainhack core. Accepts Brainfuck source as a byte stream (e.g. from a UART receiver), drops comment characters, encodes the six commands into 3-bit instructions, and writes them into program memory. It checks bracket balance and program length. When a load completes cleanly it clears the unused program memory and raises `o_run` so the top level can start the core.

## Interface
Parameters:
- `PRGMEM_ADDR_WIDTH`, default 8: program memory depth is 2^N, so 256 instructions.
- `STACK_DEPTH`, default 16: maximum `[` nesting, equal to the core's loop-stack size.
- `TERMINATOR`, default 8'h21 (`!`): end-of-program byte. 8'h00 is also always accepted as a terminator.

Ports:
- `i_clock`  in  1  the single clock; all logic is on its rising edge.
- `i_reset_n`  in  1  synchronous, active-low reset.
- `i_rx_data`  in  8  source byte.
- `i_rx_valid`  in  1  `i_rx_data` is valid.
- `o_rx_ready`  out  1  loader can accept a byte; a transfer happens when `i_rx_valid && o_rx_ready`.
- `i_reload`  in  1  single-cycle pulse; restarts loading from DONE or ERROR.
- `o_prgmem_in`  out  1  program-memory write enable.
- `o_prgmem_addr`  out  8  write address.
- `o_prgmem_data`  out  3  instruction to write.
- `o_prog_len`  out  9  number of commands loaded (0..256).
- `o_run`  out  1  program loaded and valid; core may execute.
- `o_error`  out  1  load failed.
- `o_error_code`  out  2  failure reason: 00 too long, 01 nesting overflow, 10 unmatched `]`, 11 unclosed `[`.

## Operation
Instruction encoding (fixed; the core depends on it):
- `+` 010, `-` 011, `>` 100, `<` 101, `[` 110, `]` 111.
- 000 is a nop and is used as fill.
- All other bytes, except the terminators, are comments: they are consumed and produce no write.

State machine:
- **LOAD** (entered on reset)
  - `o_rx_ready` = 1.
  - Each accepted command byte writes its encoding at address `o_prog_len`, then increments `o_prog_len`.
  - `[` increments the depth counter (5 bits). `]` decrements it.
  - Error checks, in priority order when more than one applies:
    - Command accepted while `o_prog_len` = 256 → ERROR, code 00; no write.
    - `[` accepted while depth = `STACK_DEPTH` → ERROR, code 01; no write.
    - `]` accepted while depth = 0 → ERROR, code 10; no write.
  - Terminator accepted:
    - depth ≠ 0 → ERROR, code 11.
    - otherwise → FILL.
- **FILL**
  - `o_rx_ready` = 0.
  - Writes 000 to addresses `o_prog_len` .. 255, one per cycle, then → DONE.
  - If `o_prog_len` = 256, FILL lasts 0 cycles: go directly to DONE.
- **DONE**
  - `o_run` = 1, `o_rx_ready` = 0.
  - `i_reload` → LOAD with `o_prog_len`, depth and the write address cleared, and `o_run` = 0.
- **ERROR**
  - `o_error` = 1 and `o_error_code` hold until the state is left.
  - `o_rx_ready` = 1: bytes are consumed and discarded so the sender never stalls. No writes occur.
  - `i_reload` → LOAD with everything cleared.

Other rules:
- `i_reload` is ignored in LOAD and FILL.
- The core's PC wraps from 255 to 0, so a program that runs off its end re-executes from address 0 after the nop fill. This behaviour is intended and belongs to the core.

## Timing
- Reset values: `o_rx_ready`=1 (state LOAD), `o_prgmem_in`=0, `o_prgmem_addr`=0, `o_prgmem_data`=000, `o_prog_len`=0, `o_run`=0, `o_error`=0, `o_error_code`=00.
- All outputs are registered.
- A command byte accepted in cycle N produces `o_prgmem_in`=1 with its address and data in cycle N+1, for exactly one cycle.
- Throughput: one byte per cycle. `o_rx_ready` does not depend on `i_rx_valid`.
- Terminator accepted in cycle N:
  - First FILL write is in cycle N+1.
  - DONE (`o_run`=1) is reached in cycle N+1+(256−len). For len=256 that is cycle N+1.
- An error-causing byte accepted in cycle N gives `o_error`=1 in cycle N+1.
- `i_reload` in cycle N gives `o_run`/`o_error`=0 and LOAD in cycle N+1.
- Reset asserted in any state, including mid-FILL, returns to the reset values on the next edge. A partially written memory is acceptable; `o_run`=0 marks it invalid.

## Structure
- Shared package `brainhack_pkg`: the instruction encodings (`INSTR_NOP`, `INSTR_TAPE_INC` … `INSTR_LOOP_END`), the widths matching the core (instruction 3, program address 8, stack address 4), and the error-code constants.
- One combinational sub-module, `bf_char_decoder`: byte in → {`is_cmd`, `is_term`, `instr[2:0]`}.
- The FSM, counters and write register live in `bf_program_loader`.

## Test plan
- Stream `"+[->+<]!"` → writes 010,110,011,100,010,101,111 at addresses 0–6, then 000 at 7–255; `o_prog_len`=7; `o_run`=1 exactly 250 cycles after the terminator is accepted.
- Stream `"a+ b\n-!"` → only two writes: 010@0, 011@1; `o_prog_len`=2; no error.
- 17 × `[` → ERROR code 01 the cycle after the 17th; only 16 writes; following bytes are consumed with no writes.
- `"]!"` → code 10. `"[[]!"` → code 11. Then pulse `i_reload`, stream `"+!"` → `o_run`=1, `o_prog_len`=1, `o_error`=0.
- 256 × `+` then `!` → no FILL writes; `o_run` the cycle after `!`. A 257th `+` → code 00.
- Assert `i_reset_n`=0 mid-FILL → next cycle all outputs at reset values and `o_rx_ready`=1.

Source files
------------

// File: rtl/brainhack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : brainhack_pkg
// Purpose  : Instruction encodings, widths and error codes shared with the core.
// Revision : 1.0 - initial release
// ============================================================================
package brainhack_pkg;

    localparam int INSTR_W      = 3;
    localparam int PRG_ADDR_W   = 8;
    localparam int STACK_ADDR_W = 4;

    localparam logic [INSTR_W-1:0] INSTR_NOP        = 3'b000;
    localparam logic [INSTR_W-1:0] INSTR_TAPE_INC   = 3'b010;
    localparam logic [INSTR_W-1:0] INSTR_TAPE_DEC   = 3'b011;
    localparam logic [INSTR_W-1:0] INSTR_PTR_INC    = 3'b100;
    localparam logic [INSTR_W-1:0] INSTR_PTR_DEC    = 3'b101;
    localparam logic [INSTR_W-1:0] INSTR_LOOP_START = 3'b110;
    localparam logic [INSTR_W-1:0] INSTR_LOOP_END   = 3'b111;

    localparam logic [1:0] ERR_TOO_LONG  = 2'b00;
    localparam logic [1:0] ERR_NEST_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNMATCHED = 2'b10;
    localparam logic [1:0] ERR_UNCLOSED  = 2'b11;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/bf_char_decoder.sv
`default_nettype none
// ============================================================================
// Module   : bf_char_decoder
// Purpose  : Classifies a source byte as command, terminator or comment.
// Revision : 1.0 - initial release
// ============================================================================
module bf_char_decoder
    import brainhack_pkg::*;
#(
    parameter logic [7:0] TERMINATOR = 8'h21
) (
    input  logic [7:0]         i_byte,
    output logic               o_is_cmd,
    output logic               o_is_term,
    output logic [INSTR_W-1:0] o_instr
);

    always_comb begin
        o_is_cmd  = 1'b0;
        o_is_term = 1'b0;
        o_instr   = INSTR_NOP;
        if (i_byte == 8'h00 || i_byte == TERMINATOR) begin
            o_is_term = 1'b1;
        end else begin
            o_is_cmd = 1'b1;
            case (i_byte)
                8'h2B:   o_instr = INSTR_TAPE_INC;   // '+'
                8'h2D:   o_instr = INSTR_TAPE_DEC;   // '-'
                8'h3E:   o_instr = INSTR_PTR_INC;    // '>'
                8'h3C:   o_instr = INSTR_PTR_DEC;    // '<'
                8'h5B:   o_instr = INSTR_LOOP_START; // '['
                8'h5D:   o_instr = INSTR_LOOP_END;   // ']'
                default: o_is_cmd = 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bf_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : bf_program_loader
// Purpose  : Streams Brainfuck source into program memory, checks brackets
//            and length, nop-fills the remainder and raises o_run.
// Revision : 1.0 - initial release
// ============================================================================
module bf_program_loader
    import brainhack_pkg::*;
#(
    parameter int         PRGMEM_ADDR_WIDTH = 8,
    parameter int         STACK_DEPTH       = 16,
    parameter logic [7:0] TERMINATOR        = 8'h21
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    input  logic [7:0]                   i_rx_data,
    input  logic                         i_rx_valid,
    output logic                         o_rx_ready,
    input  logic                         i_reload,
    output logic                         o_prgmem_in,
    output logic [PRGMEM_ADDR_WIDTH-1:0] o_prgmem_addr,
    output logic [INSTR_W-1:0]           o_prgmem_data,
    output logic [PRGMEM_ADDR_WIDTH:0]   o_prog_len,
    output logic                         o_run,
    output logic                         o_error,
    output logic [1:0]                   o_error_code
);

    localparam int LEN_W   = PRGMEM_ADDR_WIDTH + 1;
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam logic [LEN_W-1:0]   c_MAX_LEN   = LEN_W'(1) << PRGMEM_ADDR_WIDTH;
    localparam logic [DEPTH_W-1:0] c_MAX_DEPTH = DEPTH_W'(STACK_DEPTH);

    loader_state_t                r_state, w_state_nx;
    logic [LEN_W-1:0]             r_prog_len, w_len_nx;
    logic [LEN_W-1:0]             r_fill, w_fill_nx;
    logic [DEPTH_W-1:0]           r_depth, w_depth_nx;
    logic                         r_we, w_we_nx;
    logic [PRGMEM_ADDR_WIDTH-1:0] r_addr, w_addr_nx;
    logic [INSTR_W-1:0]           r_data, w_data_nx;
    logic                         r_run, w_run_nx;
    logic                         r_error, w_error_nx;
    logic [1:0]                   r_code, w_code_nx;
    logic                         r_rx_ready, w_rx_ready_nx;

    logic               w_is_cmd;
    logic               w_is_term;
    logic [INSTR_W-1:0] w_instr;
    logic               w_accept;

    bf_char_decoder #(
        .TERMINATOR (TERMINATOR)
    ) u_decoder (
        .i_byte    (i_rx_data),
        .o_is_cmd  (w_is_cmd),
        .o_is_term (w_is_term),
        .o_instr   (w_instr)
    );

    assign w_accept = i_rx_valid && r_rx_ready;

    always_comb begin
        w_state_nx = r_state;
        w_len_nx   = r_prog_len;
        w_fill_nx  = r_fill;
        w_depth_nx = r_depth;
        w_we_nx    = 1'b0;
        w_addr_nx  = r_addr;
        w_data_nx  = r_data;
        w_run_nx   = r_run;
        w_error_nx = r_error;
        w_code_nx  = r_code;
        case (r_state)
            ST_LOAD: begin
                if (w_accept && w_is_term) begin
                    if (r_depth != '0) begin
                        w_state_nx = ST_ERROR;
                        w_error_nx = 1'b1;
                        w_code_nx  = ERR_UNCLOSED;
                    end else if (r_prog_len == c_MAX_LEN) begin
                        w_state_nx = ST_DONE;
                        w_run_nx   = 1'b1;
                    end else begin
                        // First fill write issues together with the FILL entry.
                        w_state_nx = ST_FILL;
                        w_we_nx    = 1'b1;
                        w_addr_nx  = r_prog_len[PRGMEM_ADDR_WIDTH-1:0];
                        w_data_nx  = INSTR_NOP;
                        w_fill_nx  = r_prog_len + LEN_W'(1);
                    end
                end else if (w_accept && w_is_cmd) begin
                    if (r_prog_len == c_MAX_LEN) begin
                        w_state_nx = ST_ERROR;
                        w_error_nx = 1'b1;
                        w_code_nx  = ERR_TOO_LONG;
                    end else if (w_instr == INSTR_LOOP_START && r_depth == c_MAX_DEPTH) begin
                        w_state_nx = ST_ERROR;
                        w_error_nx = 1'b1;
                        w_code_nx  = ERR_NEST_OVF;
                    end else if (w_instr == INSTR_LOOP_END && r_depth == '0) begin
                        w_state_nx = ST_ERROR;
                        w_error_nx = 1'b1;
                        w_code_nx  = ERR_UNMATCHED;
                    end else begin
                        w_we_nx   = 1'b1;
                        w_addr_nx = r_prog_len[PRGMEM_ADDR_WIDTH-1:0];
                        w_data_nx = w_instr;
                        w_len_nx  = r_prog_len + LEN_W'(1);
                        if (w_instr == INSTR_LOOP_START) begin
                            w_depth_nx = r_depth + DEPTH_W'(1);
                        end else if (w_instr == INSTR_LOOP_END) begin
                            w_depth_nx = r_depth - DEPTH_W'(1);
                        end
                    end
                end
            end
            ST_FILL: begin
                if (r_fill == c_MAX_LEN) begin
                    w_state_nx = ST_DONE;
                    w_run_nx   = 1'b1;
                end else begin
                    w_we_nx   = 1'b1;
                    w_addr_nx = r_fill[PRGMEM_ADDR_WIDTH-1:0];
                    w_data_nx = INSTR_NOP;
                    w_fill_nx = r_fill + LEN_W'(1);
                end
            end
            ST_DONE, ST_ERROR: begin
                if (i_reload) begin
                    w_state_nx = ST_LOAD;
                    w_len_nx   = '0;
                    w_fill_nx  = '0;
                    w_depth_nx = '0;
                    w_addr_nx  = '0;
                    w_data_nx  = INSTR_NOP;
                    w_run_nx   = 1'b0;
                    w_error_nx = 1'b0;
                    w_code_nx  = 2'b00;
                end
            end
            default: w_state_nx = ST_LOAD;
        endcase
        // Registered ready keeps it independent of i_rx_valid.
        w_rx_ready_nx = (w_state_nx == ST_LOAD) || (w_state_nx == ST_ERROR);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state    <= ST_LOAD;
            r_prog_len <= '0;
            r_fill     <= '0;
            r_depth    <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= INSTR_NOP;
            r_run      <= 1'b0;
            r_error    <= 1'b0;
            r_code     <= 2'b00;
            r_rx_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nx;
            r_prog_len <= w_len_nx;
            r_fill     <= w_fill_nx;
            r_depth    <= w_depth_nx;
            r_we       <= w_we_nx;
            r_addr     <= w_addr_nx;
            r_data     <= w_data_nx;
            r_run      <= w_run_nx;
            r_error    <= w_error_nx;
            r_code     <= w_code_nx;
            r_rx_ready <= w_rx_ready_nx;
        end
    end

    assign o_rx_ready    = r_rx_ready;
    assign o_prgmem_in   = r_we;
    assign o_prgmem_addr = r_addr;
    assign o_prgmem_data = r_data;
    assign o_prog_len    = r_prog_len;
    assign o_run         = r_run;
    assign o_error       = r_error;
    assign o_error_code  = r_code;

endmodule
`default_nettype wire

// File: tb/tb_bf_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bf_program_loader
// Purpose  : Scoreboard bench for bf_program_loader with directed streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bf_program_loader;

    logic       clk;
    logic       i_reset_n;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic       o_rx_ready;
    logic       i_reload;
    logic       o_prgmem_in;
    logic [7:0] o_prgmem_addr;
    logic [2:0] o_prgmem_data;
    logic [8:0] o_prog_len;
    logic       o_run;
    logic       o_error;
    logic [1:0] o_error_code;

    typedef struct packed {
        logic [7:0] addr;
        logic [2:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;

    bf_program_loader dut (
        .i_clock       (clk),
        .i_reset_n     (i_reset_n),
        .i_rx_data     (i_rx_data),
        .i_rx_valid    (i_rx_valid),
        .o_rx_ready    (o_rx_ready),
        .i_reload      (i_reload),
        .o_prgmem_in   (o_prgmem_in),
        .o_prgmem_addr (o_prgmem_addr),
        .o_prgmem_data (o_prgmem_data),
        .o_prog_len    (o_prog_len),
        .o_run         (o_run),
        .o_error       (o_error),
        .o_error_code  (o_error_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every memory write must match the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (i_reset_n && o_prgmem_in) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: got addr %0d data %b expected no write",
                             o_prgmem_addr, o_prgmem_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (o_prgmem_addr !== e.addr || o_prgmem_data !== e.data) begin
                        miscompares++;
                        $display("FAIL write: got addr %0d data %b expected addr %0d data %b",
                                 o_prgmem_addr, o_prgmem_data, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic expect_wr(input int addr, input logic [2:0] data);
        wr_t e;
        e.addr = 8'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic expect_fill(input int from);
        for (int a = from; a < 256; a++) expect_wr(a, 3'b000);
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic pulse_reload();
        i_reload = 1'b1;
        @(posedge clk);
        #1;
        i_reload = 1'b0;
        chk("reload_run", o_run, 0);
        chk("reload_error", o_error, 0);
        chk("reload_ready", o_rx_ready, 1);
        chk("reload_len", o_prog_len, 0);
    endtask

    // Called #1 after the terminator edge; counts further edges until o_run.
    task automatic wait_run(input string name, input int exp_cycles);
        int cnt;
        cnt = 0;
        while (!o_run && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk(name, cnt, exp_cycles);
        chk({name, "_ready"}, o_rx_ready, 0);
        chk({name, "_drain"}, exp_q.size(), 0);
    endtask

    initial begin
        i_reset_n  = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        i_reload   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", o_rx_ready, 1);
        chk("rst_we", o_prgmem_in, 0);
        chk("rst_addr", o_prgmem_addr, 0);
        chk("rst_len", o_prog_len, 0);
        chk("rst_run", o_run, 0);
        chk("rst_error", o_error, 0);
        i_reset_n = 1'b1;

        // "+[->+<]!" : run 250 cycles after the terminator (249 edges past it)
        expect_wr(0, 3'b010); expect_wr(1, 3'b110); expect_wr(2, 3'b011);
        expect_wr(3, 3'b100); expect_wr(4, 3'b010); expect_wr(5, 3'b101);
        expect_wr(6, 3'b111);
        expect_fill(7);
        send_str("+[->+<]!");
        chk("t1_run_early", o_run, 0);
        wait_run("t1_run_latency", 249);
        chk("t1_len", o_prog_len, 7);
        chk("t1_err", o_error, 0);
        pulse_reload();

        // Comments are dropped
        expect_wr(0, 3'b010); expect_wr(1, 3'b011);
        expect_fill(2);
        send_str("a+ b\n-!");
        wait_run("t2_run_latency", 254);
        chk("t2_len", o_prog_len, 2);
        chk("t2_err", o_error, 0);
        pulse_reload();

        // Nesting overflow on the 17th '['
        for (int i = 0; i < 16; i++) expect_wr(i, 3'b110);
        for (int i = 0; i < 17; i++) send_byte(8'h5B);
        chk("t3_err", o_error, 1);
        chk("t3_code", o_error_code, 2'b01);
        chk("t3_ready", o_rx_ready, 1);
        send_str("+-!");
        chk("t3_err_hold", o_error, 1);
        chk("t3_code_hold", o_error_code, 2'b01);
        chk("t3_drain", exp_q.size(), 0);
        pulse_reload();

        // Unmatched ']'
        send_byte(8'h5D);
        chk("t4_err", o_error, 1);
        chk("t4_code", o_error_code, 2'b10);
        send_byte(8'h21);
        pulse_reload();

        // Unclosed '['
        expect_wr(0, 3'b110); expect_wr(1, 3'b110); expect_wr(2, 3'b111);
        send_str("[[]!");
        chk("t5_err", o_error, 1);
        chk("t5_code", o_error_code, 2'b11);
        chk("t5_drain", exp_q.size(), 0);
        pulse_reload();

        // Recovery load
        expect_wr(0, 3'b010);
        expect_fill(1);
        send_str("+!");
        wait_run("t6_run_latency", 255);
        chk("t6_len", o_prog_len, 1);
        chk("t6_err", o_error, 0);
        pulse_reload();

        // Full program: no fill, run right after the terminator
        for (int i = 0; i < 256; i++) expect_wr(i, 3'b010);
        for (int i = 0; i < 256; i++) send_byte(8'h2B);
        send_byte(8'h21);
        chk("t7_run", o_run, 1);
        chk("t7_len", o_prog_len, 256);
        @(posedge clk);
        #1;
        chk("t7_drain", exp_q.size(), 0);
        pulse_reload();

        // 257th command is too long
        for (int i = 0; i < 256; i++) expect_wr(i, 3'b010);
        for (int i = 0; i < 257; i++) send_byte(8'h2B);
        chk("t8_err", o_error, 1);
        chk("t8_code", o_error_code, 2'b00);
        chk("t8_len", o_prog_len, 256);
        chk("t8_drain", exp_q.size(), 0);
        pulse_reload();

        // Reset in the middle of FILL
        expect_wr(0, 3'b100);
        expect_fill(1);
        send_str(">!");
        repeat (5) @(posedge clk);
        #1;
        i_reset_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("t9_ready", o_rx_ready, 1);
        chk("t9_we", o_prgmem_in, 0);
        chk("t9_addr", o_prgmem_addr, 0);
        chk("t9_data", o_prgmem_data, 0);
        chk("t9_len", o_prog_len, 0);
        chk("t9_run", o_run, 0);
        chk("t9_err", o_error, 0);
        chk("t9_code", o_error_code, 0);
        i_reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t9_idle_we", o_prgmem_in, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
